// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding and the bus geometry.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: synchronous byte-enabled write port, synchronous read port.
// Contents are deliberately never reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [WORD_BYTES-1:0]     be,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [8*WORD_BYTES-1:0]   wdata,
  input  logic [IDX_W-1:0]          raddr,
  output logic [8*WORD_BYTES-1:0]   rdata
);

  logic [8*WORD_BYTES-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (we && be[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory slave: grant in IDLE, WAIT_CYCLES of wait, one RESP cycle.
// Range/alignment errors are decided from the captured request and suppress the write.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_2000,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [8*WORD_BYTES-1:0] wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [8*WORD_BYTES-1:0] rdata_o,
  output logic                    err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  // One extra bit so BASE_ADDR + size cannot wrap at the top of the address space.
  localparam logic [ADDR_W:0] LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_W+1)'(WORD_BYTES * DEPTH_WORDS);

  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic w,
                                    input logic [WORD_BYTES-1:0] b);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= LIMIT) ||
           (w && (b == '0));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> $clog2(WORD_BYTES));
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    cap_we;
  logic [WORD_BYTES-1:0]   cap_be;
  logic [ADDR_W-1:0]       cap_addr;
  logic [8*WORD_BYTES-1:0] cap_wdata;
  logic                    grant, resp_err, ram_we;
  logic [IDX_W-1:0]        ram_raddr;
  logic [8*WORD_BYTES-1:0] ram_rdata;

  assign grant    = req_i && (state == IDLE) && rst_n_i;
  assign gnt_o    = grant;
  assign resp_err = addr_err(cap_addr, cap_we, cap_be);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_i) begin
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        cap_we    <= we_i;
        cap_be    <= be_i;
        cap_addr  <= addr_i;
        cap_wdata <= wdata_i;
      end
    end
  end

  // The RAM read is issued one cycle ahead of RESP; with zero wait that cycle is the grant itself.
  assign ram_raddr = (state == IDLE) ? word_idx(addr_i) : word_idx(cap_addr);
  assign ram_we    = (state == RESP) && cap_we && !resp_err && rst_n_i;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk_i),
    .we   (ram_we),
    .be   (cap_be),
    .waddr(word_idx(cap_addr)),
    .wdata(cap_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign rvalid_o = (state == RESP);
  assign err_o    = rvalid_o && resp_err;
  assign rdata_o  = (rvalid_o && !cap_we && !resp_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build plus WAIT_CYCLES=0 and =3 builds.
// Instance index: 0 -> WAIT_CYCLES=1, 1 -> WAIT_CYCLES=0, 2 -> WAIT_CYCLES=3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  wire  [2:0]  gnt, rvalid, err;
  wire  [31:0] rdata_w1, rdata_w0, rdata_w3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata_w1), .err_o(err[0])
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata_w0), .err_o(err[1])
  );

  dmem_responder #(.WAIT_CYCLES(3)) dut_w3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[2]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata_w3), .err_o(err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] sel_rdata(input int k);
    return (k == 0) ? rdata_w1 : (k == 1) ? rdata_w0 : rdata_w3;
  endfunction

  // One transaction on instance k; lat counts cycles from grant to rvalid (0 = never seen).
  task automatic txn(input int k, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    we = w; be = b; addr = a; wdata = d; req[k] = 1'b1;
    #1;
    check("gnt_same_cycle", {31'd0, gnt[k]}, 32'd1);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    lat = 0; rd = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvalid[k]) begin
        lat = i; rd = sel_rdata(k); e = err[k];
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [9:0]  gmask, vmask;
    int          seen;

    // Reset: requests must not be granted and outputs stay quiet.
    rst_n = 1'b0;
    req   = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", {29'd0, gnt}, 32'd0);
    check("reset_rvalid", {29'd0, rvalid}, 32'd0);
    check("reset_err", {29'd0, err}, 32'd0);
    check("reset_rdata", rdata_w1, 32'd0);
    req   = 3'b000;
    rst_n = 1'b1;

    // Full-word write then readback.
    txn(0, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF, rd, e, lat);
    check("wr_lat", lat, 2); check("wr_err", {31'd0, e}, 0); check("wr_rdata", rd, 0);
    txn(0, 1'b0, 4'h0, 32'h2000, 32'h0, rd, e, lat);
    check("rd_lat", lat, 2); check("rd_err", {31'd0, e}, 0); check("rd_data", rd, 32'hDEADBEEF);

    // Single-byte write merges into the existing word.
    txn(0, 1'b1, 4'b0001, 32'h2000, 32'h0000_00AA, rd, e, lat);
    txn(0, 1'b0, 4'hF, 32'h2000, 32'h0, rd, e, lat);
    check("byte_merge", rd, 32'hDEADBEAA);

    // Error cases: misaligned, below base, past end, write with no byte enables.
    txn(0, 1'b0, 4'hF, 32'h2002, 32'h0, rd, e, lat);
    check("misalign_err", {31'd0, e}, 1); check("misalign_rdata", rd, 0);
    txn(0, 1'b0, 4'hF, 32'h1FFC, 32'h0, rd, e, lat);
    check("below_err", {31'd0, e}, 1); check("below_rdata", rd, 0);
    txn(0, 1'b1, 4'hF, 32'h3000, 32'h1234_5678, rd, e, lat);
    check("above_err", {31'd0, e}, 1); check("above_lat", lat, 2);
    txn(0, 1'b1, 4'h0, 32'h2000, 32'h5555_5555, rd, e, lat);
    check("no_be_err", {31'd0, e}, 1);
    txn(0, 1'b0, 4'hF, 32'h2000, 32'h0, rd, e, lat);
    check("err_no_change", rd, 32'hDEADBEAA);

    // Last valid word is in range.
    txn(0, 1'b1, 4'hF, 32'h2FFC, 32'hCAFE_F00D, rd, e, lat);
    check("top_wr_err", {31'd0, e}, 0);
    txn(0, 1'b0, 4'hF, 32'h2FFC, 32'h0, rd, e, lat);
    check("top_rd", rd, 32'hCAFE_F00D);

    // Held request: one transaction every three cycles.
    @(negedge clk);
    we = 1'b0; be = 4'hF; addr = 32'h2000; req[0] = 1'b1;
    gmask = '0; vmask = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      gmask[c] = gnt[0];
      vmask[c] = rvalid[0];
      @(negedge clk);
    end
    req[0] = 1'b0;
    check("held_gnt_pattern", {22'd0, gmask}, 32'h249);
    check("held_rvalid_pattern", {22'd0, vmask}, 32'h124);
    repeat (4) @(negedge clk);

    // Reset during WAIT aborts the write.
    txn(0, 1'b1, 4'hF, 32'h2004, 32'h1111_2222, rd, e, lat);
    @(negedge clk);
    we = 1'b1; be = 4'hF; addr = 32'h2004; wdata = 32'h9999_9999; req[0] = 1'b1;
    #1;
    check("abort_gnt", {31'd0, gnt[0]}, 1);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid[0]) seen++;
    end
    check("abort_no_rvalid", seen, 0);
    txn(0, 1'b0, 4'hF, 32'h2004, 32'h0, rd, e, lat);
    check("abort_old_data", rd, 32'h1111_2222);

    // Zero-wait and three-wait builds.
    txn(1, 1'b1, 4'hF, 32'h2010, 32'h0BAD_CAFE, rd, e, lat);
    check("w0_wr_lat", lat, 1);
    txn(1, 1'b0, 4'hF, 32'h2010, 32'h0, rd, e, lat);
    check("w0_rd_lat", lat, 1); check("w0_rd_data", rd, 32'h0BAD_CAFE);
    txn(2, 1'b1, 4'b1100, 32'h2020, 32'hA5A5_0000, rd, e, lat);
    check("w3_wr_lat", lat, 4);
    txn(2, 1'b0, 4'hF, 32'h2020, 32'h0, rd, e, lat);
    check("w3_rd_lat", lat, 4); check("w3_rd_hi", {16'd0, rd[31:16]}, 32'h0000_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
